// File: rtl/mimosa_pkg.sv
// Shared definitions for the mimosa mood model: sequencer states,
// saturation bounds, reset values, update deltas and thresholds.
package mimosa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC_N = 3'd1,
    ST_CALC_E = 3'd2,
    ST_CALC_S = 3'd3,
    ST_CALC_P = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  // Saturation ceiling; the floor is always 0.
  localparam int MAX_VAL = 100;

  // Power-on mood.
  localparam int RST_NOURISH  = 64;
  localparam int RST_ENERGY   = 64;
  localparam int RST_STRESS   = 0;
  localparam int RST_PLEASURE = 32;

  // Per-update deltas.
  localparam int D_FEED   = 16;
  localparam int D_LIGHT  = 2;
  localparam int D_STRESS = 8;
  localparam int D_PET    = 4;
  localparam int D_DECAY  = -1;
  localparam int D_RELAX  = -2;

  // Thresholds applied to freshly updated values.
  localparam int TH_HUNGRY   = 16;
  localparam int TH_FED      = 32;
  localparam int TH_STRESSED = 64;

endpackage

// File: rtl/sat_addsub.sv
// Combinational saturating add of a small signed delta to an unsigned
// state value; the result is clamped to [0, MAX_VAL].
module sat_addsub #(
  parameter int WIDTH   = 7,
  parameter int MAX_VAL = 100
) (
  input  logic        [WIDTH-1:0] cur,
  input  logic signed [WIDTH+1:0] delta,
  output logic        [WIDTH-1:0] result
);

  // Two guard bits: one for overflow above 2^WIDTH-1, one for sign.
  localparam logic signed [WIDTH+1:0] CEIL = (WIDTH+2)'(MAX_VAL);

  logic signed [WIDTH+1:0] sum;

  // Extend, add, then clamp at both ends.
  always_comb begin
    sum = $signed({2'b00, cur}) + delta;
    if (sum[WIDTH+1]) begin
      result = '0;
    end else if (sum > CEIL) begin
      result = WIDTH'(MAX_VAL);
    end else begin
      result = sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mood_update_sequencer.sv
// Runs one mood update (nourishment, energy, stress, pleasure) per
// prescaled model tick through a single shared saturating adder.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | waiting for an update request
//   ST_CALC_N  | nourishment written at end of cycle
//   ST_CALC_E  | energy written (sees new nourishment)
//   ST_CALC_S  | stress written
//   ST_CALC_P  | pleasure written (sees new nourishment/stress)
//   ST_DONE    | update_done pulse, stimulus flags consumed
module mood_update_sequencer
  import mimosa_pkg::*;
#(
  parameter int WIDTH      = 7,
  parameter int MAX_VAL    = mimosa_pkg::MAX_VAL,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  tick_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  stim_feed,
  input  logic                  stim_light,
  input  logic                  stim_stress,
  input  logic                  stim_pet,
  output logic [WIDTH-1:0]      nourishment,
  output logic [WIDTH-1:0]      energy,
  output logic [WIDTH-1:0]      stress,
  output logic [WIDTH-1:0]      pleasure,
  output logic                  busy,
  output logic                  update_done,
  output logic                  overrun
);

  localparam logic signed [WIDTH+1:0] DLT_FEED   = (WIDTH+2)'(D_FEED);
  localparam logic signed [WIDTH+1:0] DLT_LIGHT  = (WIDTH+2)'(D_LIGHT);
  localparam logic signed [WIDTH+1:0] DLT_STRESS = (WIDTH+2)'(D_STRESS);
  localparam logic signed [WIDTH+1:0] DLT_PET    = (WIDTH+2)'(D_PET);
  localparam logic signed [WIDTH+1:0] DLT_DECAY  = (WIDTH+2)'(D_DECAY);
  localparam logic signed [WIDTH+1:0] DLT_RELAX  = (WIDTH+2)'(D_RELAX);
  localparam logic signed [WIDTH+1:0] DLT_ZERO   = '0;

  localparam logic [WIDTH-1:0] TH_HUNGRY_V   = WIDTH'(TH_HUNGRY);
  localparam logic [WIDTH-1:0] TH_FED_V      = WIDTH'(TH_FED);
  localparam logic [WIDTH-1:0] TH_STRESSED_V = WIDTH'(TH_STRESSED);

  // tick synchroniser and edge detect
  logic tick_s1, tick_s2, tick_s3, tick_edge;

  // prescaler
  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] ps_eff;
  logic [PRESCALE_W:0]   cnt_inc;
  logic                  upd_req;

  // sequencer
  seq_state_t state_q, state_d;
  logic       pend_req_q, pend_req_d;
  logic       overrun_q, overrun_d;

  // stimulus pending flags
  logic pend_feed_q, pend_light_q, pend_stress_q, pend_pet_q;

  // mood registers and shared ALU
  logic        [WIDTH-1:0] n_q, e_q, s_q, p_q;
  logic        [WIDTH-1:0] alu_cur, alu_out;
  logic signed [WIDTH+1:0] alu_delta;

  // Two-flop synchroniser plus a registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_s1   <= 1'b0;
      tick_s2   <= 1'b0;
      tick_s3   <= 1'b0;
      tick_edge <= 1'b0;
    end else begin
      tick_s1   <= tick_in;
      tick_s2   <= tick_s1;
      tick_s3   <= tick_s2;
      tick_edge <= tick_s2 & ~tick_s3;
    end
  end

  assign ps_eff  = (prescale == '0) ? PRESCALE_W'(1) : prescale;
  assign cnt_inc = {1'b0, cnt_q} + (PRESCALE_W+1)'(1);

  // Count enabled tick edges; raise a one-cycle request on reaching ps_eff.
  // The >= compare keeps the counter from running away if prescale is
  // lowered below the current count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      upd_req <= 1'b0;
    end else begin
      upd_req <= 1'b0;
      if (ena && tick_edge) begin
        if (cnt_inc >= {1'b0, ps_eff}) begin
          cnt_q   <= '0;
          upd_req <= 1'b1;
        end else begin
          cnt_q <= cnt_inc[PRESCALE_W-1:0];
        end
      end
    end
  end

  // Sequencer state, one-deep request queue and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pend_req_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_req_q <= pend_req_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next state; IDLE and DONE share the start decision so a queued
  // request runs back-to-back with no idle gap.
  always_comb begin
    state_d    = state_q;
    pend_req_d = pend_req_q;
    overrun_d  = overrun_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (upd_req || pend_req_q) begin
          state_d    = ST_CALC_N;
          pend_req_d = upd_req && pend_req_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC_N: state_d = ST_CALC_E;
      ST_CALC_E: state_d = ST_CALC_S;
      ST_CALC_S: state_d = ST_CALC_P;
      ST_CALC_P: state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
    if ((state_q == ST_CALC_N) || (state_q == ST_CALC_E) ||
        (state_q == ST_CALC_S) || (state_q == ST_CALC_P)) begin
      if (upd_req) begin
        if (pend_req_q) overrun_d  = 1'b1;
        else            pend_req_d = 1'b1;
      end
    end
  end

  // Stimulus flags: set whenever the input is high, consumed in DONE;
  // an input still high in DONE keeps its flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_feed_q   <= 1'b0;
      pend_light_q  <= 1'b0;
      pend_stress_q <= 1'b0;
      pend_pet_q    <= 1'b0;
    end else if (state_q == ST_DONE) begin
      pend_feed_q   <= stim_feed;
      pend_light_q  <= stim_light;
      pend_stress_q <= stim_stress;
      pend_pet_q    <= stim_pet;
    end else begin
      pend_feed_q   <= pend_feed_q   | stim_feed;
      pend_light_q  <= pend_light_q  | stim_light;
      pend_stress_q <= pend_stress_q | stim_stress;
      pend_pet_q    <= pend_pet_q    | stim_pet;
    end
  end

  // ALU operand select; later variables see values written earlier
  // in the same sequence because each write lands at its state's end.
  always_comb begin
    alu_cur   = n_q;
    alu_delta = DLT_ZERO;
    case (state_q)
      ST_CALC_N: begin
        alu_cur   = n_q;
        alu_delta = pend_feed_q ? DLT_FEED : DLT_DECAY;
      end
      ST_CALC_E: begin
        alu_cur   = e_q;
        alu_delta = (pend_light_q ? DLT_LIGHT : DLT_DECAY) +
                    ((n_q < TH_HUNGRY_V) ? DLT_DECAY : DLT_ZERO);
      end
      ST_CALC_S: begin
        alu_cur   = s_q;
        alu_delta = pend_stress_q ? DLT_STRESS : DLT_RELAX;
      end
      ST_CALC_P: begin
        alu_cur = p_q;
        if (pend_pet_q && (n_q >= TH_FED_V)) alu_delta = DLT_PET;
        else if (s_q >= TH_STRESSED_V)      alu_delta = DLT_RELAX;
        else                                alu_delta = DLT_DECAY;
      end
      default: begin
        alu_cur   = n_q;
        alu_delta = DLT_ZERO;
      end
    endcase
  end

  sat_addsub #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_alu (
    .cur    (alu_cur),
    .delta  (alu_delta),
    .result (alu_out)
  );

  // Write back exactly one mood register per CALC state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= WIDTH'(RST_NOURISH);
      e_q <= WIDTH'(RST_ENERGY);
      s_q <= WIDTH'(RST_STRESS);
      p_q <= WIDTH'(RST_PLEASURE);
    end else begin
      case (state_q)
        ST_CALC_N: n_q <= alu_out;
        ST_CALC_E: e_q <= alu_out;
        ST_CALC_S: s_q <= alu_out;
        ST_CALC_P: p_q <= alu_out;
        default: ;
      endcase
    end
  end

  assign nourishment = n_q;
  assign energy      = e_q;
  assign stress      = s_q;
  assign pleasure    = p_q;
  assign busy        = (state_q != ST_IDLE);
  assign update_done = (state_q == ST_DONE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_mood_update_sequencer.sv
// Scoreboard bench for mood_update_sequencer: a behavioural model
// predicts each update when its tick is driven; the monitor pops and
// compares on every update_done pulse.
module tb_mood_update_sequencer;

  localparam int WIDTH = 7;
  localparam int PW    = 4;
  localparam int MAXV  = 100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             tick_in;
  logic [PW-1:0]    prescale;
  logic             stim_feed, stim_light, stim_stress, stim_pet;
  logic [WIDTH-1:0] nourishment, energy, stress, pleasure;
  logic             busy, update_done, overrun;

  mood_update_sequencer #(.WIDTH(WIDTH), .MAX_VAL(MAXV), .PRESCALE_W(PW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .tick_in     (tick_in),
    .prescale    (prescale),
    .stim_feed   (stim_feed),
    .stim_light  (stim_light),
    .stim_stress (stim_stress),
    .stim_pet    (stim_pet),
    .nourishment (nourishment),
    .energy      (energy),
    .stress      (stress),
    .pleasure    (pleasure),
    .busy        (busy),
    .update_done (update_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int e;
    int s;
    int p;
  } mood_t;

  mood_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    done_cnt = 0;

  // model state
  int mn, me, ms, mp, mcnt;
  bit pf, pl, pst, ppt;

  task automatic check_val(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n && update_done) begin
      mood_t m;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 1, 0);
      end else begin
        m = exp_q.pop_front();
        check_val("nourishment", int'(nourishment), m.n);
        check_val("energy",      int'(energy),      m.e);
        check_val("stress",      int'(stress),      m.s);
        check_val("pleasure",    int'(pleasure),    m.p);
      end
    end
  end

  task automatic model_update();
    mood_t m;
    mn = clamp(mn + (pf ? 16 : -1));
    me = clamp(me + (pl ? 2 : -1) + ((mn < 16) ? -1 : 0));
    ms = clamp(ms + (pst ? 8 : -2));
    if (ppt && mn >= 32)  mp = clamp(mp + 4);
    else if (ms >= 64)    mp = clamp(mp - 2);
    else                  mp = clamp(mp - 1);
    m.n = mn; m.e = me; m.s = ms; m.p = mp;
    exp_q.push_back(m);
    pf  = stim_feed;
    pl  = stim_light;
    pst = stim_stress;
    ppt = stim_pet;
  endtask

  task automatic model_reset();
    mn = 64; me = 64; ms = 0; mp = 32; mcnt = 0;
    pf = 0; pl = 0; pst = 0; ppt = 0;
    exp_q.delete();
  endtask

  task automatic set_stim(input bit f, input bit l, input bit s, input bit p);
    stim_feed = f; stim_light = l; stim_stress = s; stim_pet = p;
    if (f) pf = 1;
    if (l) pl = 1;
    if (s) pst = 1;
    if (p) ppt = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick_in = 1'b0;
    set_stim(0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One tick pulse; the model decides whether it fires an update.
  task automatic tick(input int hi, input int lo, input bit push);
    int pe;
    tick_in = 1'b1;
    repeat (hi) @(negedge clk);
    tick_in = 1'b0;
    if (ena) begin
      pe = (prescale == 0) ? 1 : int'(prescale);
      mcnt++;
      if (mcnt >= pe) begin
        mcnt = 0;
        if (push) model_update();
      end
    end
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    check_val("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, d0, prev;
    bit got, seen;
    rst_n = 1'b0; ena = 1'b1; tick_in = 1'b0; prescale = 4'd1;
    set_stim(0, 0, 0, 0);

    // 1: reset values, latency, busy width
    do_reset();
    check_val("rst_n_val",   int'(nourishment), 64);
    check_val("rst_e_val",   int'(energy),      64);
    check_val("rst_s_val",   int'(stress),      0);
    check_val("rst_p_val",   int'(pleasure),    32);
    check_val("rst_busy",    int'(busy),        0);
    check_val("rst_done",    int'(update_done), 0);
    check_val("rst_overrun", int'(overrun),     0);
    tick_in = 1'b1;
    model_update();
    lat = 0; bcnt = 0; got = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) tick_in = 1'b0;
      if (busy) bcnt++;
      if (update_done && !got) begin got = 1; lat = i; end
    end
    check_val("latency", lat, 9);
    check_val("busy_cycles", bcnt, 5);
    wait_drain(40);

    // 2: feed held, saturation, pending survives DONE
    do_reset();
    set_stim(1, 0, 0, 0);
    repeat (3) tick(2, 14, 1);
    wait_drain(40);
    check_val("n_saturated", int'(nourishment), 100);
    set_stim(0, 0, 0, 0);
    tick(2, 14, 1);
    tick(2, 14, 1);
    wait_drain(40);

    // 3: prescale 3, then prescale 0
    do_reset();
    prescale = 4'd3;
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      tick(2, 14, 1);
      if (i == 1) check_val("ps3_after_2", done_cnt - d0, 0);
      if (i == 2) check_val("ps3_after_3", done_cnt - d0, 1);
    end
    check_val("ps3_total", done_cnt - d0, 2);
    prescale = 4'd0;
    d0 = done_cnt;
    repeat (3) tick(2, 14, 1);
    check_val("ps0_total", done_cnt - d0, 3);
    wait_drain(40);

    // ena low: edges ignored
    do_reset();
    prescale = 4'd1;
    ena = 1'b0;
    d0 = done_cnt;
    tick(2, 14, 1);
    check_val("ena0_done", done_cnt - d0, 0);
    check_val("ena0_n", int'(nourishment), 64);
    ena = 1'b1;

    // 4: stress build-up, pet boost, stressed decay
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_stim(0, 0, 1, 0); @(negedge clk);
      set_stim(0, 0, 0, 0);
      tick(2, 14, 1);
    end
    wait_drain(40);
    check_val("s_reached", int'(stress), 64);
    prev = int'(pleasure);
    set_stim(0, 0, 1, 1); @(negedge clk);
    set_stim(0, 0, 0, 0);
    tick(2, 14, 1);
    wait_drain(40);
    check_val("pet_boost", int'(pleasure), prev + 4);
    prev = int'(pleasure);
    set_stim(0, 0, 1, 0); @(negedge clk);
    set_stim(0, 0, 0, 0);
    tick(2, 14, 1);
    wait_drain(40);
    check_val("stressed_decay", int'(pleasure), prev - 2);

    // 5: back-to-back requests, one queued, one dropped
    do_reset();
    check_val("ovr_before", int'(overrun), 0);
    d0 = done_cnt;
    tick(1, 1, 1);
    tick(1, 1, 1);
    tick(1, 1, 0);
    wait_drain(40);
    repeat (4) @(negedge clk);
    check_val("b2b_dones", done_cnt - d0, 2);
    check_val("ovr_set", int'(overrun), 1);
    repeat (10) @(negedge clk);
    check_val("ovr_sticky", int'(overrun), 1);

    // 6: reset during CALC_S
    do_reset();
    d0 = done_cnt;
    tick(2, 0, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) begin seen = 1; break; end
      @(negedge clk);
    end
    check_val("mid_busy_seen", int'(seen), 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_n", int'(nourishment), 64);
    check_val("mid_rst_e", int'(energy),      64);
    check_val("mid_rst_s", int'(stress),      0);
    check_val("mid_rst_p", int'(pleasure),    32);
    check_val("mid_rst_busy", int'(busy),     0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("mid_rst_no_done", done_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mood_update_sequencer.md
Name: mood_update_sequencer

Overview:
Sequences one model update of the mimosa's four internal state variables (nourishment, energy, stress, pleasure) per prescaled model tick. A single shared saturating add/sub unit is time-multiplexed across the four variables in a fixed order. Stimulus requests are latched until the next update consumes them. The block sits between the tick/stimulus inputs (the tick is derived from ui_in[0]) and the mood-to-output mapping logic, and drives the dbg_* state observation buses.

Parameters:
WIDTH, 7, bit width of each state variable
MAX_VAL, 100, saturation ceiling for every state variable (floor is 0)
PRESCALE_W, 4, width of the prescale input

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  block enable; when low, ticks are ignored and the prescaler holds
tick_in  in  1  raw model tick (ui_in[0]); asynchronous to clk, synchronised internally
prescale  in  PRESCALE_W  tick rising edges per update; 0 is treated as 1
stim_feed  in  1  feed request (level)
stim_light  in  1  light request (level)
stim_stress  in  1  stress request (level)
stim_pet  in  1  pet request (level)
nourishment  out  WIDTH  state value
energy  out  WIDTH  state value
stress  out  WIDTH  state value
pleasure  out  WIDTH  state value
busy  out  1  update sequence in progress
update_done  out  1  one-cycle pulse when an update completes
overrun  out  1  sticky: an update request was dropped

Behaviour:
- Reset values: nourishment=64, energy=64, stress=0, pleasure=32, busy=0, update_done=0, overrun=0; prescale counter=0; all pending flags=0; FSM=IDLE.
- tick_in path: 2-flop synchroniser, then a rising-edge detect register. A tick edge is seen 3 clk cycles after tick_in rises. With ena=1, each edge increments the prescale counter. When the count reaches max(prescale,1), the counter clears and an update request is raised.
- Request while busy: latch exactly one pending request and service it immediately after DONE. A further request while one is already pending is dropped and sets overrun. overrun clears only on reset.
- ena=0: edges are ignored and the counter holds. A sequence already in progress completes, and a pending request is still serviced.
- Stimulus pending flags: set in any cycle the input is high. Cleared in the DONE cycle. If the input is high in the DONE cycle, set wins and the flag stays pending.
- FSM: IDLE -> CALC_N -> CALC_E -> CALC_S -> CALC_P -> DONE -> IDLE. One cycle per state.
  - busy is high in CALC_N through DONE.
  - update_done is high in DONE only.
  - Each variable's register updates at the end of its CALC state, so all new values are visible from the DONE cycle onward.
  - Update latency: 6 cycles from request to the end of DONE.
- Shared ALU: computes cur + signed delta at WIDTH+2 bits signed, then clamps to [0, MAX_VAL]. Exactly one variable is written per cycle.
- Delta rules (conditions use values already updated earlier in the same sequence):
  - N: +16 if feed pending, else -1.
  - E: +2 if light pending, else -1; an additional -1 if new nourishment < 16.
  - S: +8 if stress pending, else -2.
  - P: +4 if pet pending and new nourishment >= 32; else -2 if new stress >= 64; else -1.
- Reset mid-sequence: all state returns to reset values immediately and the partial update is discarded.

Decomposition:
- Shared package mimosa_pkg holds:
  - the FSM state enum;
  - constants MAX_VAL and the reset values (64, 64, 0, 32);
  - the delta constants (16, 2, 8, 4, -1, -2) and thresholds (16, 32, 64).
- One natural sub-module: sat_addsub (combinational clamp-add over [0, MAX_VAL]), instantiated once as the shared unit.
- The synchroniser stays inline.

Test Plan:
1. Reset, prescale=1, ena=1, one tick_in pulse, no stimuli -> update_done 9 cycles after tick rise; N=63, E=63, S=0 (clamped), P=31; busy high for exactly 5 cycles.
2. Hold stim_feed high, 3 ticks -> N=80, 96, then 100 (saturated). E=63, 62, 61. stim_feed held through DONE keeps its pending flag set.
3. prescale=3, 6 tick pulses -> exactly 2 update_done pulses, after the 3rd and 6th edges. Repeat with prescale=0 -> one update per edge.
4. stim_stress pulsed once per tick for 8 ticks -> S reaches 64. On the next tick with stim_pet high and no feed (N=55 at that point, so >= 32), P=+4; on a tick without pet, P decreases by 2 (since S >= 64).
5. Three back-to-back tick requests during one sequence (prescale=1, tick period 2 cycles) -> one extra update is serviced right after DONE, overrun=1 and stays 1.
6. Assert rst_n low during CALC_S -> outputs return to 64/64/0/32 and busy=0 asynchronously; no update_done pulse follows.
